// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the TinyALU command sequencer.
package tinyalu_pkg;

   localparam int ALU_W = 8;
   localparam int RES_W = 16;
   localparam int OP_W  = 3;

   // Opcodes 5..7 have no enum member; they travel as raw codes and are
   // reported as illegal.
   typedef enum logic [OP_W-1:0] {
      OP_NOP = 3'd0,
      OP_ADD = 3'd1,
      OP_AND = 3'd2,
      OP_XOR = 3'd3,
      OP_MUL = 3'd4
   } alu_op_e;

   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic [OP_W-1:0]  op;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } seq_state_e;

   // True for opcodes that need the external ALU.
   function automatic logic op_uses_alu(input logic [OP_W-1:0] op);
      return (op != 3'(OP_NOP)) && (op <= 3'(OP_MUL));
   endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Command queue for the TinyALU sequencer: power-of-two depth, generic
// element type, combinational head. A push while full is accepted only when
// a pop happens on the same edge, leaving occupancy unchanged.
module tinyalu_cmd_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);

   T               mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q;
   logic [AW:0]    rd_ptr_q;
   logic           do_push;
   logic           do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer update; the extra MSB tells full from empty.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers gate reads.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/tinyalu_cmd_seq.sv
// TinyALU command sequencer: queues {a,b,op} commands, issues them to an
// external ALU one at a time and returns each result through a single-entry
// output register with a valid/ready handshake.
//
// Optional build macro TINYALU_SEQ_WATCHDOG_EN adds an ISSUE-state timeout
// that emits an error result and parks in HOLD for one cycle.
//
// state | meaning
// IDLE  | fetch queue head into the staging register, then issue or
//       | answer NOP/illegal directly
// ISSUE | alu_start held high with stable operands until alu_done
// DRAIN | wait for alu_done to drop before the next command
// HOLD  | one-cycle park after a watchdog timeout
module tinyalu_cmd_seq
   import tinyalu_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ALU_W-1:0] cmd_a,
   input  logic [ALU_W-1:0] cmd_b,
   input  logic [OP_W-1:0]  cmd_op,
   output logic [ALU_W-1:0] alu_a,
   output logic [ALU_W-1:0] alu_b,
   output logic [OP_W-1:0]  alu_op,
   output logic             alu_start,
   input  logic             alu_done,
   input  logic [RES_W-1:0] alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic [OP_W-1:0]  res_op,
   output logic             res_err,
   output logic             busy
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("tinyalu_cmd_seq: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
   end

   seq_state_e       state_q;
   cmd_t             stg_q;
   logic             stg_vld_q;
   logic [ALU_W-1:0] alu_a_q;
   logic [ALU_W-1:0] alu_b_q;
   logic [OP_W-1:0]  alu_op_q;
   logic             alu_start_q;
   logic             res_valid_q;
   logic [RES_W-1:0] res_data_q;
   logic [OP_W-1:0]  res_op_q;
   logic             res_err_q;

   cmd_t             fifo_in;
   cmd_t             fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;

`ifdef TINYALU_SEQ_WATCHDOG_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] wd_q;
`endif

   assign cmd_ready    = !fifo_full && !reset;
   assign fifo_push    = cmd_valid && cmd_ready;
   assign fifo_in.a    = cmd_a;
   assign fifo_in.b    = cmd_b;
   assign fifo_in.op   = cmd_op;

   // The head is only taken when nothing waits in staging or in the output
   // register, so an issued command always has somewhere to land.
   assign fifo_pop = (state_q == ST_IDLE) && !stg_vld_q && !fifo_empty &&
                     !res_valid_q;

   tinyalu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (cmd_t)
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (fifo_push),
      .data_i  (fifo_in),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Sequencer FSM with all ALU and result outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         stg_q       <= '0;
         stg_vld_q   <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_start_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= '0;
         res_err_q   <= 1'b0;
`ifdef TINYALU_SEQ_WATCHDOG_EN
         wd_q        <= '0;
`endif
      end else begin
         if (res_valid_q && res_ready) res_valid_q <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (stg_vld_q) begin
                  stg_vld_q <= 1'b0;
                  if (op_uses_alu(stg_q.op)) begin
                     alu_a_q     <= stg_q.a;
                     alu_b_q     <= stg_q.b;
                     alu_op_q    <= stg_q.op;
                     alu_start_q <= 1'b1;
                     state_q     <= ST_ISSUE;
`ifdef TINYALU_SEQ_WATCHDOG_EN
                     wd_q        <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
                  end else begin
                     // NOP and illegal codes never reach the ALU.
                     res_data_q  <= '0;
                     res_op_q    <= stg_q.op;
                     res_err_q   <= (stg_q.op != 3'(OP_NOP));
                     res_valid_q <= 1'b1;
                  end
               end else if (fifo_pop) begin
                  stg_q     <= fifo_head;
                  stg_vld_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (alu_done) begin
                  res_data_q  <= alu_result;
                  res_op_q    <= alu_op_q;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
                  alu_start_q <= 1'b0;
                  state_q     <= ST_DRAIN;
               end
`ifdef TINYALU_SEQ_WATCHDOG_EN
               else if (wd_q == '0) begin
                  res_data_q  <= '0;
                  res_op_q    <= alu_op_q;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  alu_start_q <= 1'b0;
                  state_q     <= ST_HOLD;
               end else begin
                  wd_q <= wd_q - 1'b1;
               end
`endif
            end
            ST_DRAIN: begin
               if (!alu_done) state_q <= ST_IDLE;
            end
            ST_HOLD: begin
               state_q <= ST_DRAIN;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign alu_start = alu_start_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign res_err   = res_err_q;
   assign busy      = (state_q != ST_IDLE) || stg_vld_q || !fifo_empty;

endmodule

// File: tb/tb_tinyalu_cmd_seq.sv
// Bench for tinyalu_cmd_seq: a behavioural ALU (single-cycle logic ops,
// 3-cycle MUL, optional hang), a scoreboard of expected results computed
// from the opcode rules, directed latency/reset cases and a random phase.
module tb_tinyalu_cmd_seq;

   localparam int TO = 15;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  op;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [2:0]  res_op;
   logic        res_err;
   logic        busy;

   logic        alu_hang;
   int          mul_cnt;
   int          cyc;
   int          n_vec;
   int          n_err;
   int          n_res;
   int          st_rise, st_fall, rv_rise;
   logic        prev_st, prev_rv;
   bit          rnd_done;
   exp_t        exp_q[$];

   tinyalu_cmd_seq #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_op     (res_op),
      .res_err    (res_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected result of one command from the opcode table.
   function automatic exp_t ref_res(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] op);
      exp_t r;
      r.op   = op;
      r.err  = 1'b0;
      r.data = 16'h0000;
      case (op)
         3'd0: r.data = 16'h0000;
         3'd1: r.data = 16'(a) + 16'(b);
         3'd2: r.data = {8'h00, a & b};
         3'd3: r.data = {8'h00, a ^ b};
         3'd4: r.data = 16'(a) * 16'(b);
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   // Behavioural ALU: logic ops answer in the cycle start is seen, MUL after
   // start has been sampled on three edges.
   always @(posedge clk) mul_cnt <= alu_start ? mul_cnt + 1 : 0;
   assign alu_done   = alu_start && !alu_hang && ((alu_op == 3'd4) ? (mul_cnt >= 3) : 1'b1);
   assign alu_result = ref_res(alu_a, alu_b, alu_op).data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Result monitor and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         prev_st = 1'b0;
         prev_rv = 1'b0;
      end else begin
         if (alu_start && !prev_st) st_rise = cyc;
         if (!alu_start && prev_st) st_fall = cyc;
         if (res_valid && !prev_rv) rv_rise = cyc;
         if (res_valid && res_ready) begin
            n_res++;
            if (exp_q.size() == 0) begin
               chk("res_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("res_data", res_data, e.data);
               chk("res_op", res_op, e.op);
               chk("res_err", res_err, e.err);
            end
         end
         prev_st = alu_start;
         prev_rv = res_valid;
      end
   end

   // Offer one command; returns the cycle number of the accepting edge.
   // Called and returns at posedge+1.
   task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input bit wd_expire,
                           output int k);
      bit   rdy;
      bit   done;
      exp_t e;
      done      = 0;
      k         = -1;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         rdy = cmd_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1;
            k    = cyc;
            e    = ref_res(a, b, op);
            if (wd_expire) begin
               e.data = 16'h0000;
               e.err  = 1'b1;
            end
            exp_q.push_back(e);
         end
      end
      cmd_valid = 1'b0;
      if (!done) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_res(input int target, input int max_cyc, input string tag);
      int n = 0;
      while (n_res < target && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n_res >= target), 32'd1);
   endtask

   task automatic wait_drain(input int max_cyc, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy || res_valid) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(exp_q.size() == 0 && !busy && !res_valid), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int k1;
      int saved;
      n_vec     = 0;
      n_err     = 0;
      n_res     = 0;
      cyc       = 0;
      st_rise   = 0;
      st_fall   = 0;
      rv_rise   = 0;
      rnd_done  = 0;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      res_ready = 1'b1;
      alu_hang  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready_low", cmd_ready, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_alu_start", alu_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_alu_op", alu_op, 0);
      @(posedge clk);
      #1;

      // ADD 0xFF + 0x01 with an empty pipe
      saved = n_res;
      push_cmd(8'hFF, 8'h01, 3'd1, 0, k);
      wait_res(saved + 1, 20, "add_result_seen");
      chk("add_start_lat", st_rise - k, 2);
      chk("add_valid_lat", rv_rise - k, 3);
      wait_drain(20, "add_drain");

      // MUL 0xFF * 0xFF: start held until done
      saved = n_res;
      push_cmd(8'hFF, 8'hFF, 3'd4, 0, k);
      wait_res(saved + 1, 20, "mul_result_seen");
      chk("mul_start_lat", st_rise - k, 2);
      chk("mul_valid_lat", rv_rise - k, 6);
      chk("mul_start_fall", st_fall - k, 6);
      wait_drain(20, "mul_drain");

      // Back-to-back burst with the result side stalled. The XOR leaves the
      // queue for the ALU first, so the queue fills on the fifth push.
      res_ready = 1'b0;
      push_cmd(8'hAA, 8'h55, 3'd3, 0, k1);
      push_cmd(8'h12, 8'h34, 3'd0, 0, k);
      push_cmd(8'h56, 8'h78, 3'd7, 0, k);
      push_cmd(8'hF0, 8'h3C, 3'd2, 0, k);
      push_cmd(8'h03, 8'h04, 3'd4, 0, k);
      chk("burst_back_to_back", k - k1, 4);
      @(negedge clk);
      chk("burst_cmd_ready_low", cmd_ready, 0);
      repeat (20) @(negedge clk);
      chk("burst_stall_valid", res_valid, 1);
      chk("burst_stall_ready", cmd_ready, 0);
      chk("burst_stall_count", n_res, 2);
      @(posedge clk);
      #1 res_ready = 1'b1;
      wait_drain(100, "burst_drain");

      // Reset in the middle of a MUL issue
      push_cmd(8'h03, 8'h05, 3'd4, 0, k);
      for (int n = 0; n < 20 && !alu_start; n++) @(negedge clk);
      chk("rst_mid_started", alu_start, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      saved = n_res;
      @(negedge clk);
      chk("rst_mid_alu_start", alu_start, 0);
      chk("rst_mid_res_valid", res_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 1);
      repeat (10) @(negedge clk);
      chk("rst_mid_no_result", n_res, saved);
      @(posedge clk);
      #1;

`ifdef TINYALU_SEQ_WATCHDOG_EN
      // ALU hangs on an ADD; the watchdog answers, the next command is normal.
      alu_hang = 1'b1;
      saved    = n_res;
      push_cmd(8'h11, 8'h22, 3'd1, 1, k1);
      push_cmd(8'h0F, 8'hFC, 3'd2, 0, k);
      wait_res(saved + 1, 2 * TO + 20, "wd_result_seen");
      alu_hang = 1'b0;
      chk("wd_valid_lat", rv_rise - k1, 2 + TO);
      wait_drain(40, "wd_drain");
`endif

      // Random commands with random gaps and random result back-pressure
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               int gap;
               gap = $urandom_range(0, 2);
               for (int g = 0; g < gap; g++) begin
                  @(posedge clk);
                  #1;
               end
               push_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 0, k);
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               res_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      res_ready = 1'b1;
      wait_drain(800, "rand_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
